branch_predictor: RTL and testbench

//  Fetch-stage branch predictor: direct-mapped BHT (2-bit saturating counters) + tagged BTB.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped table of 2-bit saturating counters with a tagged
// target buffer. Lookup is combinational on PCF; training and statistics come from execute.
module branch_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    output logic            PredictedF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            update_en,
    input  logic            jumpE,
    input  logic [XLEN-1:0] PCE,
    input  logic            ActualE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredictedE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;
    localparam int DEPTH    = 2 ** INDEX_BITS;

    logic                  w_valid  [DEPTH];
    logic [TAG_BITS-1:0]   w_tag    [DEPTH];
    logic [XLEN-1:0]       w_target [DEPTH];
    logic [1:0]            w_ctr    [DEPTH];

    logic [INDEX_BITS-1:0] w_idx_f, w_idx_e;
    logic [TAG_BITS-1:0]   w_tag_f, w_tag_e;
    logic                  w_hit_f, w_hit_e;
    logic                  w_mispredict;
    logic                  w_unused;

    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    assign w_idx_f  = PCF[INDEX_BITS+1:2];
    assign w_tag_f  = PCF[XLEN-1:INDEX_BITS+2];
    assign w_idx_e  = PCE[INDEX_BITS+1:2];
    assign w_tag_e  = PCE[XLEN-1:INDEX_BITS+2];
    assign w_unused = ^{PCF[1:0], PCE[1:0]};

    assign w_hit_f = w_valid[w_idx_f] && (w_tag[w_idx_f] == w_tag_f);
    assign w_hit_e = w_valid[w_idx_e] && (w_tag[w_idx_e] == w_tag_e);

    assign PredictedF  = w_hit_f && w_ctr[w_idx_f][1];
    assign PredTargetF = PredictedF ? w_target[w_idx_f] : PCF + XLEN'(4);

    // Each entry lives in its own block so the table is written from exactly one process per slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                r_valid;
            logic [TAG_BITS-1:0] r_tag;
            logic [XLEN-1:0]     r_target;
            logic [1:0]          r_ctr;
            logic                w_sel;

            assign w_sel = update_en && (w_idx_e == INDEX_BITS'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= '0;
                    r_ctr    <= 2'b01;
                end else if (w_sel) begin
                    if (w_hit_e) begin
                        if (jumpE) begin
                            r_ctr    <= 2'b11;
                            r_target <= TargetE;
                        end else if (ActualE) begin
                            r_ctr    <= (r_ctr == 2'b11) ? 2'b11 : r_ctr + 2'b01;
                            r_target <= TargetE;
                        end else begin
                            r_ctr    <= (r_ctr == 2'b00) ? 2'b00 : r_ctr - 2'b01;
                        end
                    end else if (ActualE) begin
                        r_valid  <= 1'b1;
                        r_tag    <= w_tag_e;
                        r_target <= TargetE;
                        r_ctr    <= jumpE ? 2'b11 : 2'b10;
                    end
                end
            end

            assign w_valid[gi]  = r_valid;
            assign w_tag[gi]    = r_tag;
            assign w_target[gi] = r_target;
            assign w_ctr[gi]    = r_ctr;
        end
    endgenerate

    // A taken prediction that went to the wrong place is as costly as a wrong direction.
    assign w_mispredict = (PredictedE != ActualE) ||
                          (PredictedE && ActualE && (PredTargetE != TargetE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (update_en) begin
            if (r_branch_count != 32'hFFFF_FFFF)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF))
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checks of branch_predictor against a table-of-records reference model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        PredictedF;
    logic [31:0] PredTargetF;
    logic        update_en;
    logic        jumpE;
    logic [31:0] PCE;
    logic        ActualE;
    logic [31:0] TargetE;
    logic        PredictedE;
    logic [31:0] PredTargetE;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredictedF(PredictedF), .PredTargetF(PredTargetF),
        .update_en(update_en), .jumpE(jumpE), .PCE(PCE), .ActualE(ActualE), .TargetE(TargetE),
        .PredictedE(PredictedE), .PredTargetE(PredTargetE),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference: one record per slot, keyed by the full upper PC, counter kept as a plain int.
    bit          m_valid [64];
    logic [31:0] m_upper [64];
    logic [31:0] m_target[64];
    int          m_ctr   [64];
    longint      m_bc, m_mc;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_upper[slot(pc)] == (pc >> 8));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        return m_pred(pc) ? m_target[slot(pc)] : nxt;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_upper[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic m_train(input bit jmp, input logic [31:0] pc, input bit act,
                           input logic [31:0] tgt, input bit pe, input logic [31:0] pte);
        int s;
        bool_wrong: begin end
        s = slot(pc);
        if (m_hit(pc)) begin
            if (jmp) begin
                m_ctr[s] = 3; m_target[s] = tgt;
            end else if (act) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1; m_target[s] = tgt;
            end else begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (act) begin
            m_valid[s] = 1; m_upper[s] = pc >> 8; m_target[s] = tgt; m_ctr[s] = jmp ? 3 : 2;
        end
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (((pe != act) || (pe && act && pte != tgt)) && m_mc < 64'hFFFF_FFFF) m_mc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check lookup before the edge, check stats after it.
    task automatic step(input logic [31:0] pcf, input bit upd, input bit jmp,
                        input logic [31:0] pce, input bit act, input logic [31:0] tgt,
                        input bit pe, input logic [31:0] pte);
        PCF = pcf; update_en = upd; jumpE = jmp; PCE = pce; ActualE = act;
        TargetE = tgt; PredictedE = pe; PredTargetE = pte;
        #1;
        chk("PredictedF", {31'd0, PredictedF}, {31'd0, m_pred(pcf)});
        chk("PredTargetF", PredTargetF, m_ptgt(pcf));
        @(posedge clk);
        if (upd) m_train(jmp, pce, act, tgt, pe, pte);
        #1;
        chk("branch_count", branch_count, m_bc[31:0]);
        chk("mispredict_count", mispredict_count, m_mc[31:0]);
        $display("step pcf=%h upd=%0d jmp=%0d pce=%h act=%0d tgt=%h -> predF=%0d tgtF=%h bc=%0d mc=%0d",
                 pcf, upd, jmp, pce, act, tgt, PredictedF, PredTargetF, branch_count, mispredict_count);
        @(negedge clk);
    endtask

    // Look up without training.
    task automatic look(input logic [31:0] pcf);
        step(pcf, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // Train using the model's own view of what fetch predicted for that PC.
    task automatic train(input logic [31:0] pce, input bit jmp, input bit act, input logic [31:0] tgt);
        step(pce, 1, jmp, pce, act, tgt, m_pred(pce), m_ptgt(pce));
    endtask

    initial begin
        logic [31:0] pc, tg;
        bit          up, jp, ac;

        m_reset();
        rst_n = 1'b0; PCF = 32'h100; update_en = 0; jumpE = 0; PCE = 0; ActualE = 0;
        TargetE = 0; PredictedE = 0; PredTargetE = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_PredictedF", {31'd0, PredictedF}, 32'd0);
        chk("rst_PredTargetF", PredTargetF, 32'h104);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: same-cycle lookup sees pre-edge contents, next cycle sees the allocation.
        step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        look(32'h100);
        chk("T2_PredTargetF", PredTargetF, 32'h80);

        // T3: saturate up, then two not-takens drop below the taken threshold.
        repeat (3) train(32'h100, 0, 1, 32'h80);
        train(32'h100, 0, 0, 32'h0);
        look(32'h100);
        chk("T3_still_taken", {31'd0, PredictedF}, 32'd1);
        train(32'h100, 0, 0, 32'h0);
        look(32'h100);
        chk("T3_not_taken_tgt", PredTargetF, 32'h104);

        // T4: same slot, different tag replaces the entry.
        train(32'h200, 0, 1, 32'h280);
        look(32'h100);
        look(32'h200);
        chk("T4_alias_tgt", PredTargetF, 32'h280);

        // T5: jump with a stale predicted target counts as a mispredict.
        step(32'h40, 1, 1, 32'h40, 1, 32'h400, 1, 32'h300);
        look(32'h40);
        chk("T5_jump_tgt", PredTargetF, 32'h400);

        // PCF+4 wraps at the top of the address space.
        look(32'hFFFF_FFFC);
        chk("wrap_PredTargetF", PredTargetF, 32'h0);

        // T6: reset mid-update discards the update and clears everything.
        PCF = 32'h300; update_en = 1; jumpE = 1; PCE = 32'h300; ActualE = 1; TargetE = 32'h500;
        PredictedE = 0; PredTargetE = 32'h304;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        m_reset();
        chk("midrst_branch_count", branch_count, 32'd0);
        chk("midrst_mispredict_count", mispredict_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        look(32'h300);
        look(32'h200);

        for (int k = 0; k < 10; k++)
            step(32'h1000 + 32'(k * 4), 1, 0, 32'h1000 + 32'(k * 4), 0, 32'h0, k < 3, 32'h0);
        chk("T6_branch_count", branch_count, 32'd10);
        chk("T6_mispredict_count", mispredict_count, 32'd3);

        // Saturation: preload both counters just below the ceiling.
        force dut.r_branch_count = 32'hFFFF_FFFE;
        force dut.r_mispredict_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_branch_count;
        release dut.r_mispredict_count;
        m_bc = 64'hFFFF_FFFE; m_mc = 64'hFFFF_FFFE;
        repeat (3) step(32'h2000, 1, 0, 32'h2000, 0, 32'h0, 1, 32'h0);
        chk("sat_branch_count", branch_count, 32'hFFFF_FFFF);
        chk("sat_mispredict_count", mispredict_count, 32'hFFFF_FFFF);

        // Randomized traffic over a few tags and slots to exercise hits, aliasing and saturation.
        for (int n = 0; n < 400; n++) begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) pc = $urandom;
            tg = {$urandom_range(0, 255), 2'b00};
            up = ($urandom_range(0, 3) != 0);
            jp = ($urandom_range(0, 4) == 0);
            ac = jp ? 1'b1 : 1'(($urandom_range(0, 2)) != 0);
            if (up)
                step(pc, 1, jp, pc, ac, tg, m_pred(pc), $urandom_range(0, 1) ? m_ptgt(pc) : tg);
            else
                step(pc, 0, jp, $urandom, ac, $urandom, 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
